// File: rtl/pc_ctrl_if.sv
// pc_ctrl_if: control, table-config and status signals of the PC sequencer
interface pc_ctrl_if #(parameter int D = 12, parameter int A = 6);
  logic start, stall, branch, taken, abs_jump, halt, cfg_we;
  logic [A-1:0] lut_addr, cfg_addr;
  logic [D-1:0] cfg_data, pc;
  logic running, done;
  logic [15:0] taken_cnt;
  modport master(output start, stall, branch, taken, abs_jump, halt, cfg_we, lut_addr, cfg_addr, cfg_data,
                 input pc, running, done, taken_cnt);
  modport slave(input start, stall, branch, taken, abs_jump, halt, cfg_we, lut_addr, cfg_addr, cfg_data,
                output pc, running, done, taken_cnt);
endinterface

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch-stage PC sequencer with runtime-writable branch-target table
module pc_ctrl #(parameter int D = 12, parameter int A = 6) (
  input logic clk,
  input logic reset_n,
  pc_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [D-1:0] lut [2**A];
  logic [D-1:0] ent;
  logic go;
  // combinational read: a same-edge write to this index lands after the branch uses it
  assign ent = lut[bus.lut_addr];
  assign go = bus.branch & bus.taken;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) lut <= '{default: '0};
    else if (bus.cfg_we) lut[bus.cfg_addr] <= bus.cfg_data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      bus.pc <= '0;
      bus.running <= 1'b0;
      bus.done <= 1'b0;
      bus.taken_cnt <= '0;
    end else
      case (state)
        IDLE:
          if (bus.start) begin
            state <= RUN;
            bus.running <= 1'b1;
            bus.taken_cnt <= '0;
          end
        RUN:
          if (!bus.stall) begin
            if (bus.halt) begin
              state <= DONE;
              bus.running <= 1'b0;
              bus.done <= 1'b1;
            end else begin
              bus.pc <= go ? (bus.abs_jump ? ent : bus.pc + ent) : bus.pc + 1'b1;
              if (go && bus.taken_cnt != 16'hFFFF) bus.taken_cnt <= bus.taken_cnt + 16'd1;
            end
          end
        DONE: begin
          state <= IDLE;
          bus.done <= 1'b0;
          bus.pc <= '0;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: randomized and directed checks of pc_ctrl against a behavioural model
module tb_pc_ctrl;
  logic clk = 0;
  logic reset_n = 0;
  int errors = 0;
  int checks = 0;
  pc_ctrl_if #(.D(12), .A(6)) bus();
  pc_ctrl #(.D(12), .A(6)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  initial forever #5 clk = ~clk;

  int m_pc, m_cnt, e;
  bit m_run, m_done;
  int m_lut [64];

  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      m_pc = 0; m_cnt = 0; m_run = 0; m_done = 0;
      foreach (m_lut[i]) m_lut[i] = 0;
    end else begin
      e = m_lut[bus.lut_addr];
      if (m_done) begin
        m_done = 0; m_pc = 0;
      end else if (!m_run) begin
        if (bus.start) begin m_run = 1; m_cnt = 0; end
      end else if (!bus.stall) begin
        if (bus.halt) begin
          m_run = 0; m_done = 1;
        end else if (bus.branch && bus.taken) begin
          m_pc = bus.abs_jump ? e : (m_pc + e) % 4096;
          m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        end else m_pc = (m_pc + 1) % 4096;
      end
      if (bus.cfg_we) m_lut[bus.cfg_addr] = bus.cfg_data;
    end

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_pc", bus.pc, m_pc);
    chk("model_running", bus.running, m_run);
    chk("model_done", bus.done, m_done);
    chk("model_cnt", bus.taken_cnt, m_cnt);
  end

  task automatic clear_in();
    bus.start = 0; bus.stall = 0; bus.branch = 0; bus.taken = 0; bus.abs_jump = 0;
    bus.halt = 0; bus.cfg_we = 0; bus.lut_addr = 0; bus.cfg_addr = 0; bus.cfg_data = 0;
  endtask

  task automatic cfg(int a, int d);
    bus.cfg_we = 1; bus.cfg_addr = 6'(a); bus.cfg_data = 12'(d);
    @(negedge clk);
    bus.cfg_we = 0;
  endtask

  task automatic tbr(int a, bit ab);
    bus.branch = 1; bus.taken = 1; bus.abs_jump = ab; bus.lut_addr = 6'(a);
    @(negedge clk);
  endtask

  initial begin
    clear_in();
    repeat (2) @(negedge clk);
    chk("reset_pc", bus.pc, 0);
    chk("reset_running", bus.running, 0);
    reset_n = 1;
    @(negedge clk);
    cfg(0, 12'hFFB); cfg(1, 12'h014); cfg(2, 12'hFFF); cfg(3, 12'h100);
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    chk("start_running", bus.running, 1);
    chk("start_pc", bus.pc, 0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("seq_pc", bus.pc, i);
    end
    chk("seq_cnt", bus.taken_cnt, 0);
    tbr(0, 0); chk("rel_neg", bus.pc, 12'hFFF);
    tbr(1, 0); chk("rel_pos", bus.pc, 12'h013);
    tbr(2, 0); chk("rel_m1", bus.pc, 12'h012);
    chk("cnt3", bus.taken_cnt, 3);
    bus.taken = 0;
    @(negedge clk);
    chk("not_taken_pc", bus.pc, 12'h013);
    chk("not_taken_cnt", bus.taken_cnt, 3);
    tbr(3, 1); chk("abs_pc", bus.pc, 12'h100);
    bus.branch = 0;
    cfg(4, 12'hFFF);
    tbr(4, 1); chk("abs_top", bus.pc, 12'hFFF);
    bus.branch = 0;
    @(negedge clk);
    chk("wrap_pc", bus.pc, 0);
    bus.cfg_we = 1; bus.cfg_addr = 5; bus.cfg_data = 12'h010;
    tbr(5, 0);
    bus.cfg_we = 0;
    chk("conflict_old", bus.pc, 0);
    tbr(5, 0); chk("conflict_new", bus.pc, 12'h010);
    bus.branch = 0; bus.stall = 1; bus.halt = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_pc", bus.pc, 12'h010);
      chk("stall_done", bus.done, 0);
    end
    bus.stall = 0;
    @(negedge clk);
    bus.halt = 0;
    chk("done_pulse", bus.done, 1);
    chk("done_pc", bus.pc, 12'h010);
    chk("done_running", bus.running, 0);
    @(negedge clk);
    chk("idle_done", bus.done, 0);
    chk("idle_pc", bus.pc, 0);
    chk("idle_cnt", bus.taken_cnt, 7);
    for (int i = 0; i < 3000; i++) begin
      bus.start = ($urandom_range(0, 9) == 0);
      bus.stall = ($urandom_range(0, 4) == 0);
      bus.halt = ($urandom_range(0, 39) == 0);
      bus.branch = $urandom_range(0, 1);
      bus.taken = $urandom_range(0, 1);
      bus.abs_jump = ($urandom_range(0, 3) == 0);
      bus.lut_addr = 6'($urandom_range(0, 7));
      bus.cfg_we = ($urandom_range(0, 9) == 0);
      bus.cfg_addr = 6'($urandom_range(0, 7));
      bus.cfg_data = 12'($urandom_range(0, 4095));
      @(negedge clk);
    end
    clear_in();
    bus.halt = 1;
    repeat (3) @(negedge clk);
    bus.halt = 0;
    repeat (2) @(negedge clk);
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    tbr(1, 0);
    bus.branch = 0;
    chk("pre_reset_cnt", bus.taken_cnt, 1);
    #2 reset_n = 0;
    #1;
    chk("async_pc", bus.pc, 0);
    chk("async_running", bus.running, 0);
    chk("async_done", bus.done, 0);
    chk("async_cnt", bus.taken_cnt, 0);
    @(negedge clk);
    #2 reset_n = 1;
    @(negedge clk);
    chk("post_reset_done", bus.done, 0);
    cfg(6, 1);
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    bus.branch = 1; bus.taken = 1; bus.lut_addr = 6;
    repeat (65540) @(negedge clk);
    chk("sat_cnt", bus.taken_cnt, 16'hFFFF);
    chk("sat_pc", bus.pc, 4);
    bus.branch = 0; bus.halt = 1;
    @(negedge clk);
    bus.halt = 0;
    repeat (2) @(negedge clk);
    chk("sat_hold", bus.taken_cnt, 16'hFFFF);
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    chk("restart_cnt", bus.taken_cnt, 0);
    chk("restart_running", bus.running, 1);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
